dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory (data_mem) between two requesters:
//  port 0 = core load/store path, port 1 = host/DMA preload-dump engine.
//  Round-robin grant per access beat, optional bounded lock for bursts,
//  registered read return. Sits between the core, the loader and data_mem.
// PARAMETERS
//  AW        8  address width (data_mem depth 2**AW)
//  DW        8  data width
//  MAX_LOCK  4  max consecutive beats one locked port holds the grant while the other waits (>=1; 1 = lock ignored)
// PORTS
//  CLK         in   1   clock, rising edge
//  Reset       in   1   asynchronous, active-high reset
//  req0/req1   in   1   access request, level, one beat per granted cycle
//  we0/we1     in   1   1 = write, 0 = read
//  lock0/lock1 in   1   request to keep grant for following beats
//  addr0/addr1 in   AW  access address
//  wdata0/1    in   DW  write data
//  gnt0/gnt1   out  1   access performed this cycle
//  rdata0/1    out  DW  read data, registered
//  rvalid0/1   out  1   one-cycle pulse, rdata valid
//  mem_addr    out  AW  to data_mem
//  mem_wdata   out  DW  to data_mem
//  mem_we      out  1   to data_mem write enable
//  mem_rdata   in   DW  from data_mem, combinational read
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, last=1 (port 0 wins first tie),
//   lock_cnt=0, gnt*=0, rvalid*=0, rdata*=0, mem_we=0, mem_addr=0, mem_wdata=0.
//  States IDLE, OWN0, OWN1 (registered). gnt_i = (state==OWNi) & req_i (comb).
//  Requester holds addr/we/wdata/req stable until the cycle gnt_i is high;
//   beat completes in that cycle; req still high next cycle = new beat.
//  mem_* comb mux: gnt_i -> mem_addr=addr_i, mem_wdata=wdata_i, mem_we=we_i;
//   no grant -> all zero. Never both gnt high.
//  Transitions at rising CLK (o = other port):
//   IDLE: both req -> OWN(!last); only req_i -> OWNi; none -> IDLE.
//   OWNi, req_o=0: req_i -> OWNi, else IDLE; lock_cnt<=0.
//   OWNi, req_o=1: if req_i & lock_i & lock_cnt<MAX_LOCK-1 -> OWNi, lock_cnt++;
//    else -> OWNo, lock_cnt<=0.
//   On every edge with gnt_i high: last<=i.
//  Latency: IDLE->first gnt = 1 cycle; switch between ports = 0 bubble;
//   sole requester streams 1 beat/cycle; no lock + contention -> strict
//   alternation.
//  Read return: edge ending a gnt_i & ~we_i cycle: rdata_i<=mem_rdata,
//   rvalid_i<=1 (one cycle); otherwise rvalid_i<=0, rdata_i holds.
//  Writes produce no rvalid. Address wrap not applicable (AW covers full mem).
//  req_i dropped while OWNi: gnt_i low at once, no mem access, next edge
//   follows table above.
//  Reset mid-access: gnt/mem_we drop immediately; in-flight read discarded
//   (no rvalid); requester must reissue.
//  lock_cnt width $clog2(MAX_LOCK+1); cannot exceed MAX_LOCK-1.
// TESTING
//  1 core[5]=8'h3C; after reset req0 read addr 5 -> gnt0 high next cycle,
//    rvalid0 following cycle, rdata0=8'h3C, mem_we stays 0.
//  2 req0,req1 held high, no lock, 6 cycles -> gnt0,gnt1,gnt0,gnt1,... port 0
//    first; mem_addr tracks granted port each cycle.
//  3 MAX_LOCK=4, req0+lock0 and req1 held -> gnt0 4 consecutive cycles, then
//    gnt1 1 cycle, then gnt0 again.
//  4 req1 write addr 8'hFF data 8'hA5, port 0 idle -> mem_we one cycle,
//    core[255]=8'hA5; req1 read 8'hFF -> rdata1=8'hA5, rvalid1 pulse.
//  5 port 0 reads addr 0,1,2 back-to-back (core=11,22,33) -> gnt0 3 cycles,
//    rvalid0 3 cycles with rdata0 11,22,33 in order.
//  6 Reset asserted mid-cycle during gnt1 write burst -> gnt1, mem_we, rvalid*
//    low before next edge; after release with both req -> port 0 granted first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: round-robin per beat,
// bounded lock for bursts, registered read return per port.
module dmem_arbiter #(
  parameter int AW       = 8,
  parameter int DW       = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic          CLK,
  input  logic          Reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic          lock0,
  input  logic          lock1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] LOCK_LIM = CW'(MAX_LOCK - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;

  always_comb begin
    gnt0 = (state == OWN0) && req0;
    gnt1 = (state == OWN1) && req1;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_we    = we0;
    end else if (gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
    end
  end

  always_comb begin
    state_nxt    = state;
    lock_cnt_nxt = lock_cnt;
    last_nxt     = last;
    if (gnt0)      last_nxt = 1'b0;
    else if (gnt1) last_nxt = 1'b1;
    unique case (state)
      IDLE: begin
        if (req0 && req1) state_nxt = last ? OWN0 : OWN1;
        else if (req0)    state_nxt = OWN0;
        else if (req1)    state_nxt = OWN1;
      end
      OWN0: begin
        if (!req1) begin
          state_nxt    = req0 ? OWN0 : IDLE;
          lock_cnt_nxt = '0;
        end else if (req0 && lock0 && (lock_cnt < LOCK_LIM)) begin
          lock_cnt_nxt = lock_cnt + CW'(1);
        end else begin
          state_nxt    = OWN1;
          lock_cnt_nxt = '0;
        end
      end
      OWN1: begin
        if (!req0) begin
          state_nxt    = req1 ? OWN1 : IDLE;
          lock_cnt_nxt = '0;
        end else if (req1 && lock1 && (lock_cnt < LOCK_LIM)) begin
          lock_cnt_nxt = lock_cnt + CW'(1);
        end else begin
          state_nxt    = OWN0;
          lock_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt    = IDLE;
        lock_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      lock_cnt <= '0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      lock_cnt <= lock_cnt_nxt;
    end
  end

  // Read data is captured from the memory's combinational output at the edge ending the beat.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rdata0  <= '0;
      rdata1  <= '0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
      if (gnt0 && !we0) rdata0 <= mem_rdata;
      if (gnt1 && !we1) rdata1 <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: per-cycle vector table plus a
// scoreboard for read returns and a hand-written reset-mid-burst sequence.
module tb_dmem_arbiter;

  logic       CLK = 1'b0;
  logic       Reset;
  logic       req0, req1, we0, we1, lock0, lock1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wdata;
  wire  [7:0] mem_rdata;

  int errors = 0;
  int checks = 0;
  int unsigned cyc = 0;

  logic [7:0] mem [256];

  typedef struct {
    int unsigned due;
    logic [7:0]  data;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  typedef struct {
    logic       r0, w0, l0;
    logic [7:0] a0, d0;
    logic       r1, w1, l1;
    logic [7:0] a1, d1;
    logic       g0, g1, mwe;
    logic [7:0] maddr, x0, x1;
  } vec_t;
  vec_t vecs[$];

  dmem_arbiter #(.AW(8), .DW(8), .MAX_LOCK(4)) dut (
    .CLK(CLK), .Reset(Reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rdata0(rdata0), .rdata1(rdata1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  assign mem_rdata = mem[mem_addr];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h05] = 8'h3C;
    mem[8'h00] = 8'h11;
    mem[8'h01] = 8'h22;
    mem[8'h02] = 8'h33;
    mem[8'h10] = 8'hC1;
    mem[8'h20] = 8'hD2;
    forever begin
      @(posedge CLK);
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Each cycle, a port either owes exactly one scheduled read return or must stay quiet.
  always @(negedge CLK) begin
    if (q0.size() > 0 && q0[0].due == cyc) begin
      chk("rvalid0", rvalid0, 1);
      chk("rdata0", rdata0, q0[0].data);
      void'(q0.pop_front());
    end else begin
      chk("rvalid0_idle", rvalid0, 0);
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      chk("rvalid1", rvalid1, 1);
      chk("rdata1", rdata1, q1[0].data);
      void'(q1.pop_front());
    end else begin
      chk("rvalid1_idle", rvalid1, 0);
    end
  end

  function automatic vec_t mk(
    input logic r0, w0, l0, input logic [7:0] a0, d0,
    input logic r1, w1, l1, input logic [7:0] a1, d1,
    input logic g0, g1, mwe, input logic [7:0] maddr, x0, x1);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.maddr = maddr; v.x0 = x0; v.x1 = x1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req0 = v.r0; we0 = v.w0; lock0 = v.l0; addr0 = v.a0; wdata0 = v.d0;
    req1 = v.r1; we1 = v.w1; lock1 = v.l1; addr1 = v.a1; wdata1 = v.d1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t z;
    vec_t v;
    logic [7:0] exp_wd;
    logic got;
    z = mk(0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00,8'h00);

    // contention, no lock: port 0 first after reset, then strict alternation
    vecs.push_back(mk(1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h00, 0,0,0,8'h00,8'h00,8'h00));
    for (int i = 0; i < 3; i++) begin
      vecs.push_back(mk(1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h00, 1,0,0,8'h10,8'hC1,8'h00));
      vecs.push_back(mk(1,0,0,8'h10,8'h00, 1,0,0,8'h20,8'h00, 0,1,0,8'h20,8'h00,8'hD2));
    end
    vecs.push_back(z);
    // single read of addr 5
    vecs.push_back(mk(1,0,0,8'h05,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00,8'h00));
    vecs.push_back(mk(1,0,0,8'h05,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,8'h05,8'h3C,8'h00));
    vecs.push_back(z);
    // back-to-back reads 0,1,2
    vecs.push_back(mk(1,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00,8'h00));
    vecs.push_back(mk(1,0,0,8'h00,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,8'h00,8'h11,8'h00));
    vecs.push_back(mk(1,0,0,8'h01,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,8'h01,8'h22,8'h00));
    vecs.push_back(mk(1,0,0,8'h02,8'h00, 0,0,0,8'h00,8'h00, 1,0,0,8'h02,8'h33,8'h00));
    vecs.push_back(z);
    // port 1 write FF then read it back in the following beat
    vecs.push_back(mk(0,0,0,8'h00,8'h00, 1,1,0,8'hFF,8'hA5, 0,0,0,8'h00,8'h00,8'h00));
    vecs.push_back(mk(0,0,0,8'h00,8'h00, 1,1,0,8'hFF,8'hA5, 0,1,1,8'hFF,8'h00,8'h00));
    vecs.push_back(mk(0,0,0,8'h00,8'h00, 1,0,0,8'hFF,8'h00, 0,1,0,8'hFF,8'h00,8'hA5));
    vecs.push_back(z);
    // lock0 with port 1 waiting: 4 beats port 0, 1 beat port 1, port 0 again
    vecs.push_back(mk(1,0,1,8'h01,8'h00, 1,0,0,8'h02,8'h00, 0,0,0,8'h00,8'h00,8'h00));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1,0,1,8'h01,8'h00, 1,0,0,8'h02,8'h00, 1,0,0,8'h01,8'h22,8'h00));
    vecs.push_back(mk(1,0,1,8'h01,8'h00, 1,0,0,8'h02,8'h00, 0,1,0,8'h02,8'h00,8'h33));
    vecs.push_back(mk(1,0,1,8'h01,8'h00, 1,0,0,8'h02,8'h00, 1,0,0,8'h01,8'h22,8'h00));
    vecs.push_back(z);

    Reset = 1'b1;
    drive(z);
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    repeat (2) @(posedge CLK);
    #1 Reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(posedge CLK);
      #1 drive(v);
      @(negedge CLK);
      exp_wd = v.g0 ? v.d0 : (v.g1 ? v.d1 : 8'h00);
      chk($sformatf("v%0d_gnt0", i), gnt0, v.g0);
      chk($sformatf("v%0d_gnt1", i), gnt1, v.g1);
      chk($sformatf("v%0d_mem_we", i), mem_we, v.mwe);
      chk($sformatf("v%0d_mem_addr", i), mem_addr, v.maddr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, exp_wd);
      #1;
      if (v.g0 && !v.w0) q0.push_back('{due: cyc + 1, data: v.x0});
      if (v.g1 && !v.w1) q1.push_back('{due: cyc + 1, data: v.x1});
    end
    repeat (2) @(negedge CLK);
    chk("mem_ff_written", mem[8'hFF], 8'hA5);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    // reset asserted in the middle of a port-1 write burst
    @(posedge CLK);
    #1;
    drive(z);
    req1 = 1'b1; we1 = 1'b1; addr1 = 8'h40; wdata1 = 8'h5A;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      @(negedge CLK);
      if (gnt1) got = 1'b1;
    end
    chk("t6_gnt1_seen", got, 1);
    Reset = 1'b1;
    q0.delete();
    q1.delete();
    #1;
    chk("t6_gnt1_low", gnt1, 0);
    chk("t6_mem_we_low", mem_we, 0);
    chk("t6_rvalid0_low", rvalid0, 0);
    chk("t6_rvalid1_low", rvalid1, 0);
    chk("t6_rdata0_clr", rdata0, 0);
    chk("t6_rdata1_clr", rdata1, 0);
    @(posedge CLK);
    #1;
    Reset = 1'b0;
    drive(z);
    req0 = 1'b1; addr0 = 8'h05;
    req1 = 1'b1; addr1 = 8'h20;
    @(negedge CLK);
    chk("t6_idle_gnt0", gnt0, 0);
    chk("t6_idle_gnt1", gnt1, 0);
    @(negedge CLK);
    chk("t6_first_gnt0", gnt0, 1);
    chk("t6_first_gnt1", gnt1, 0);
    #1 q0.push_back('{due: cyc + 1, data: 8'h3C});
    @(negedge CLK);
    chk("t6_second_gnt0", gnt0, 0);
    chk("t6_second_gnt1", gnt1, 1);
    #1 q1.push_back('{due: cyc + 1, data: 8'hD2});
    @(posedge CLK);
    #1 drive(z);
    repeat (3) @(negedge CLK);
    chk("t6_q0_drained", q0.size(), 0);
    chk("t6_q1_drained", q1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
